ram8_word_master: RTL and testbench
===================================

// Module: ram8_word_master
//
// PURPOSE
// Bus master for the 8-bit single-port RAM interface (en/wr/addr/din/dout, combinational read).
// Accepts 16-bit word or 8-bit byte requests from a CPU/DMA client via valid/ready handshake.
// Sequences one or two byte cycles on the RAM port and returns one response per request.
// Sits between the core's load/store unit and the 32 KiB byte RAM.
//
// PARAMETERS
// BIG_ENDIAN  0  0: low byte at even address (little-endian); 1: high byte at even address
//
// PORTS
// clk         in   1   system clock, all state on rising edge
// reset       in   1   synchronous, active-high reset
// req_valid   in   1   client request present
// req_ready   out  1   master can accept request this cycle
// req_wr      in   1   1=write, 0=read
// req_byte    in   1   1=byte access, 0=word access
// req_addr    in   15  byte address
// req_wdata   in   16  write data; byte access uses [7:0]
// resp_valid  out  1   one-cycle pulse: request complete
// resp_rdata  out  16  read data, valid with resp_valid; byte reads zero-extended
// resp_err    out  1   unaligned-word fault, valid with resp_valid
// ram_en      out  1   RAM enable
// ram_wr      out  1   RAM write strobe, qualified by ram_en
// ram_addr    out  15  RAM byte address
// ram_din     out  8   RAM write data
// ram_dout    in   8   RAM read data, combinational from ram_addr
//
// BEHAVIOUR
// - FSM states: IDLE, FIRST, SECOND, DONE. Reset -> IDLE.
// - Reset values: resp_valid=0, resp_rdata=0, resp_err=0, ram_en=0, ram_wr=0, ram_addr=0, ram_din=0.
// - req_ready = (state==IDLE) & ~reset. Transfer when req_valid & req_ready; wr/byte/addr/wdata latched.
// - No back-pressure on response; client must accept resp_valid when it pulses.
// - RAM outputs decoded from registered state/latches only; no combinational path req_* -> ram_*.
// - Word: FIRST drives addr {a[14:1],0}, SECOND drives {a[14:1],1}; ram_en=1 both cycles, ram_wr=req_wr.
// - Lane mapping BIG_ENDIAN=0: even<->data[7:0], odd<->data[15:8]; BIG_ENDIAN=1 swapped.
// - Reads: ram_dout captured at end of each RAM cycle into the mapped lane of resp_rdata.
// - Byte: FIRST only, addr=a (bit0 honoured), din=wdata[7:0]; SECOND skipped; rdata={8'h00,byte}.
// - DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata holds until next DONE.
// - Latency (accept edge = cycle 0): word resp_valid in cycle 3, byte in cycle 2.
// - Throughput: one word per 4 cycles, one byte per 3 cycles; req_ready low FIRST..DONE.
// - Writes: resp_rdata not updated; resp_valid still pulses.
// - Address wrap: 0x7FFE word touches 0x7FFE/0x7FFF only; no carry beyond 15 bits.
// - Reset mid-operation: next cycle IDLE, ram_en=0, no resp_valid; partial word write is not undone.
// - req_valid while busy is ignored (not queued); client holds it until req_ready.
//
// CONFIGURATION
// RAM8_ALIGN_CHECK_EN defined: word request with req_addr[0]=1 -> no RAM cycles; IDLE->DONE
//   directly, resp_valid with resp_err=1, resp_rdata unchanged. Latency 1.
// RAM8_ALIGN_CHECK_EN undefined: resp_err tied 0; req_addr[0] ignored for word accesses.
//
// TESTING
// 1. Word write addr 0x0100 data 0xBEEF, BIG_ENDIAN=0 -> RAM[0x100]=0xEF, RAM[0x101]=0xBE, resp_valid cycle 3.
// 2. Word read 0x0100 after (1) -> resp_rdata=0xBEEF at cycle 3; BIG_ENDIAN=1 same RAM -> 0xEFBE.
// 3. Byte write 0x0203 data 0x125A -> single ram_en cycle at 0x0203 with din 0x5A; byte read -> 0x005A.
// 4. Word read 0x0101: with RAM8_ALIGN_CHECK_EN -> resp_err=1 cycle 1, ram_en never high;
//    without -> reads 0x0100/0x0101, resp_err=0.
// 5. reset asserted during SECOND of word write 0x0300 -> ram_en=0 next cycle, no resp_valid,
//    RAM[0x300] written, RAM[0x301] unchanged, req_ready=1 after reset release.
// 6. req_valid held, three word reads 0x0000/0x0002/0x7FFE -> accepted every 4 cycles, three
//    resp_valid pulses, last accesses 0x7FFE/0x7FFF with no wrap.

Source files
------------

// File: rtl/ram8_word_master.sv
// ram8_word_master
//
// Bus master that turns 16-bit word or 8-bit byte requests from a load/store
// client into one or two byte cycles on an 8-bit single-port RAM. The RAM
// read port is combinational. Each accepted request produces exactly one
// response pulse.
//
// Parameters
//   BIG_ENDIAN   0: even address carries data[7:0] (little-endian)
//                1: even address carries data[15:8]
//
// Build option
//   RAM8_ALIGN_CHECK_EN  when defined, a word request with req_addr[0]=1 skips
//                        all RAM cycles and returns resp_err=1 one cycle after
//                        acceptance. When undefined, resp_err is always 0 and
//                        req_addr[0] is ignored for word accesses.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, low in reset)
//   req_wr, req_byte      1=write/0=read, 1=byte/0=word
//   req_addr[14:0]        byte address
//   req_wdata[15:0]       write data (byte writes use [7:0])
//   resp_valid            single-cycle completion pulse
//   resp_rdata[15:0]      read data, held until the next completion
//   resp_err              unaligned-word fault, qualified by resp_valid
//   ram_en, ram_wr        RAM enable and write strobe
//   ram_addr[14:0]        RAM byte address
//   ram_din[7:0]          RAM write data
//   ram_dout[7:0]         RAM read data (combinational from ram_addr)

module ram8_word_master #(
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [14:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q;
  logic        byte_q;
  logic [14:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [7:0]  even_byte_q;   // first (even-address) byte of a word read
  logic [15:0] rdata_q;

  logic        accept;
  logic        misaligned;
  logic [7:0]  even_lane;
  logic [7:0]  odd_lane;

  assign accept = req_valid & req_ready;

`ifdef RAM8_ALIGN_CHECK_EN
  assign misaligned = ~req_byte & req_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Write data lanes for the even and odd byte of a word.
  assign even_lane = (BIG_ENDIAN != 0) ? wdata_q[15:8] : wdata_q[7:0];
  assign odd_lane  = (BIG_ENDIAN != 0) ? wdata_q[7:0]  : wdata_q[15:8];

  assign resp_rdata = rdata_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misaligned ? DONE : FIRST;
      FIRST:   state_d = byte_q ? DONE : SECOND;
      SECOND:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode works only from registered state and latched request
  // fields. Everything is forced low while reset is high, so a reset that
  // lands in the middle of a word write stops the second byte from being
  // written on the same edge.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    ram_en     = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (!reset) begin
      case (state_q)
        IDLE: req_ready = 1'b1;
        FIRST: begin
          ram_en   = 1'b1;
          ram_wr   = wr_q;
          ram_addr = byte_q ? addr_q : {addr_q[14:1], 1'b0};
          ram_din  = byte_q ? wdata_q[7:0] : even_lane;
        end
        SECOND: begin
          ram_en   = 1'b1;
          ram_wr   = wr_q;
          ram_addr = {addr_q[14:1], 1'b1};
          ram_din  = odd_lane;
        end
        DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      even_byte_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_wr;
        byte_q  <= req_byte;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misaligned;
      end
      // resp_rdata only changes on the edge into DONE, so the previous
      // result stays visible for the whole of a new request.
      if (state_q == FIRST && !wr_q) begin
        if (byte_q) rdata_q     <= {8'h00, ram_dout};
        else        even_byte_q <= ram_dout;
      end
      if (state_q == SECOND && !wr_q) begin
        rdata_q <= (BIG_ENDIAN != 0) ? {even_byte_q, ram_dout}
                                     : {ram_dout, even_byte_q};
      end
    end
  end

endmodule

// File: tb/tb_ram8_word_master.sv
// Bench for ram8_word_master. dut0 (little-endian) owns a byte RAM model.
// dut1 (big-endian) receives the same request stream and reads the same RAM,
// but its writes are dropped, so its read data shows the swapped lane order.

module tb_ram8_word_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_wr, req_byte;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;

  logic        req_ready0, resp_valid0, resp_err0, ram_en0, ram_wr0;
  logic [15:0] resp_rdata0;
  logic [14:0] ram_addr0;
  logic [7:0]  ram_din0, ram_dout0;

  logic        req_ready1, resp_valid1, resp_err1, ram_en1, ram_wr1;
  logic [15:0] resp_rdata1;
  logic [14:0] ram_addr1;
  logic [7:0]  ram_din1, ram_dout1;

  ram8_word_master #(.BIG_ENDIAN(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready0), .req_wr(req_wr),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .ram_en(ram_en0), .ram_wr(ram_wr0), .ram_addr(ram_addr0),
    .ram_din(ram_din0), .ram_dout(ram_dout0)
  );

  ram8_word_master #(.BIG_ENDIAN(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready1), .req_wr(req_wr),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .ram_en(ram_en1), .ram_wr(ram_wr1), .ram_addr(ram_addr1),
    .ram_din(ram_din1), .ram_dout(ram_dout1)
  );

  // Byte RAM model
  logic [7:0] mem [0:32767];
  always @(posedge clk) if (ram_en0 && ram_wr0) mem[ram_addr0] <= ram_din0;
  assign ram_dout0 = mem[ram_addr0];
  assign ram_dout1 = mem[ram_addr1];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [15:0] rdata; logic err; int lat; } exp_t;
  typedef struct { logic [14:0] addr; logic wr; logic [7:0] din0; logic [7:0] din1; } acc_t;

  exp_t sb_q[$];
  acc_t acc_q[$];
  int   accepts[$];
  int   cyc = 0;
  int   last_accept = 0;
  int   resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (req_valid && req_ready0) begin
      last_accept = cyc + 1;
      accepts.push_back(cyc + 1);
    end
    if (ram_en0) acc_q.push_back('{ram_addr0, ram_wr0, ram_din0, ram_din1});
    if (ram_en0 || ram_en1 || resp_valid0 || resp_valid1)
      chk("lockstep", 32'({ram_en1, ram_wr1, ram_addr1, req_ready1, resp_valid1}),
                      32'({ram_en0, ram_wr0, ram_addr0, req_ready0, resp_valid0}));
    if (resp_valid0) begin
      resp_cnt++;
      chk("resp_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("resp_rdata", 32'(resp_rdata0), 32'(e.rdata));
        chk("resp_err", 32'(resp_err0), 32'(e.err));
        chk("resp_latency", 32'(cyc + 1 - last_accept), 32'(e.lat));
      end
    end
  end

  // Issue one request; expected response goes to the scoreboard first.
  // With hold=1 the task returns right after acceptance, leaving req_valid high.
  task automatic issue(input logic wr, input logic b, input logic [14:0] a,
                       input logic [15:0] d, input logic [15:0] er,
                       input logic ee, input int el, input bit hold);
    int n = 0;
    int target;
    target = resp_cnt + 1;
    sb_q.push_back('{er, ee, el});
    req_valid = 1'b1; req_wr = wr; req_byte = b; req_addr = a; req_wdata = d;
    while (!req_ready0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(req_ready0), 32'd1);
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0;
      n = 0;
      while (resp_cnt != target && n < 10) begin @(posedge clk); #1; n++; end
      chk("resp_wait", 32'(resp_cnt), 32'(target));
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic [14:0] a,
                         input logic w, input logic [7:0] d);
    acc_t e;
    e = '{15'h0, 1'b0, 8'h00, 8'h00};
    if (idx < acc_q.size()) e = acc_q[idx];
    chk(tag, 32'({e.addr, e.wr, (e.wr ? e.din0 : 8'h00)}), 32'({a, w, d}));
  endtask

`ifdef RAM8_ALIGN_CHECK_EN
  localparam logic [15:0] LAST4 = 16'h005A;
`else
  localparam logic [15:0] LAST4 = 16'hBEEF;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int n;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 32'({req_ready0, resp_valid0, resp_err0, ram_en0, ram_wr0}), 32'd0);
    chk("reset_ram_bus", 32'({ram_addr0, ram_din0}), 32'd0);
    chk("reset_rdata", 32'(resp_rdata0), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(req_ready0), 32'd1);

    // 1: word write 0x0100 = 0xBEEF
    acc_q.delete();
    issue(1'b1, 1'b0, 15'h0100, 16'hBEEF, 16'h0000, 1'b0, 3, 1'b0);
    chk("w1_nacc", 32'(acc_q.size()), 32'd2);
    chk_acc("w1_acc0", 0, 15'h0100, 1'b1, 8'hEF);
    chk_acc("w1_acc1", 1, 15'h0101, 1'b1, 8'hBE);
    if (acc_q.size() > 0) chk("w1_be_din", 32'(acc_q[0].din1), 32'h0BE);
    chk("w1_mem", 32'({mem[15'h0100], mem[15'h0101]}), 32'h0000EFBE);

    // 2: word read 0x0100 in both lane orders
    acc_q.delete();
    issue(1'b0, 1'b0, 15'h0100, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b0);
    chk("r2_nacc", 32'(acc_q.size()), 32'd2);
    chk_acc("r2_acc0", 0, 15'h0100, 1'b0, 8'h00);
    chk_acc("r2_acc1", 1, 15'h0101, 1'b0, 8'h00);
    chk("r2_be_rdata", 32'(resp_rdata1), 32'h0000EFBE);
    chk("r2_be_err", 32'(resp_err1), 32'd0);

    // 3: byte write then byte read at odd address 0x0203
    acc_q.delete();
    issue(1'b1, 1'b1, 15'h0203, 16'h125A, 16'hBEEF, 1'b0, 2, 1'b0);
    chk("bw3_nacc", 32'(acc_q.size()), 32'd1);
    chk_acc("bw3_acc0", 0, 15'h0203, 1'b1, 8'h5A);
    acc_q.delete();
    issue(1'b0, 1'b1, 15'h0203, 16'h0000, 16'h005A, 1'b0, 2, 1'b0);
    chk("br3_nacc", 32'(acc_q.size()), 32'd1);
    chk_acc("br3_acc0", 0, 15'h0203, 1'b0, 8'h00);

    // 4: unaligned word read 0x0101
    acc_q.delete();
`ifdef RAM8_ALIGN_CHECK_EN
    issue(1'b0, 1'b0, 15'h0101, 16'h0000, 16'h005A, 1'b1, 1, 1'b0);
    chk("u4_nacc", 32'(acc_q.size()), 32'd0);
`else
    issue(1'b0, 1'b0, 15'h0101, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b0);
    chk("u4_nacc", 32'(acc_q.size()), 32'd2);
    chk_acc("u4_acc0", 0, 15'h0100, 1'b0, 8'h00);
    chk_acc("u4_acc1", 1, 15'h0101, 1'b0, 8'h00);
`endif

    // 5: reset during SECOND of word write 0x0300
    issue(1'b1, 1'b1, 15'h0301, 16'h00A5, LAST4, 1'b0, 2, 1'b0);
    issue(1'b1, 1'b1, 15'h0300, 16'h0000, LAST4, 1'b0, 2, 1'b0);
    rc = resp_cnt;
    req_valid = 1'b1; req_wr = 1'b1; req_byte = 1'b0;
    req_addr = 15'h0300; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst5_first", 32'({ram_en0, ram_addr0}), 32'({1'b1, 15'h0300}));
    @(posedge clk); #1;
    chk("rst5_second", 32'({ram_en0, ram_addr0}), 32'({1'b1, 15'h0301}));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst5_en_low", 32'(ram_en0), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst5_ready", 32'(req_ready0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst5_no_resp", 32'(resp_cnt), 32'(rc));
    chk("rst5_mem", 32'({mem[15'h0300], mem[15'h0301]}), 32'h000034A5);
    chk("rst5_rdata", 32'(resp_rdata0), 32'd0);

    // 6: held req_valid, three back-to-back word reads incl. top of memory
    issue(1'b1, 1'b0, 15'h0000, 16'hA1B2, 16'h0000, 1'b0, 3, 1'b0);
    issue(1'b1, 1'b0, 15'h0002, 16'hC3D4, 16'h0000, 1'b0, 3, 1'b0);
    issue(1'b1, 1'b0, 15'h7FFE, 16'hE5F6, 16'h0000, 1'b0, 3, 1'b0);
    acc_q.delete();
    accepts.delete();
    rc = resp_cnt;
    issue(1'b0, 1'b0, 15'h0000, 16'h0000, 16'hA1B2, 1'b0, 3, 1'b1);
    issue(1'b0, 1'b0, 15'h0002, 16'h0000, 16'hC3D4, 1'b0, 3, 1'b1);
    issue(1'b0, 1'b0, 15'h7FFE, 16'h0000, 16'hE5F6, 1'b0, 3, 1'b1);
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt != rc + 3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b6_resp_cnt", 32'(resp_cnt), 32'(rc + 3));
    chk("b6_accepts", 32'(accepts.size()), 32'd3);
    if (accepts.size() == 3) begin
      chk("b6_gap1", 32'(accepts[1] - accepts[0]), 32'd4);
      chk("b6_gap2", 32'(accepts[2] - accepts[1]), 32'd4);
    end
    chk("b6_nacc", 32'(acc_q.size()), 32'd6);
    chk_acc("b6_acc0", 0, 15'h0000, 1'b0, 8'h00);
    chk_acc("b6_acc3", 3, 15'h0003, 1'b0, 8'h00);
    chk_acc("b6_acc4", 4, 15'h7FFE, 1'b0, 8'h00);
    chk_acc("b6_acc5", 5, 15'h7FFF, 1'b0, 8'h00);
    chk("b6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
